// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus bit meanings.
`timescale 1ns / 1ps
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } i2c_state_e;

  localparam logic I2C_RD  = 1'b1;
  localparam logic I2C_ACK = 1'b0;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the SCL/SDA pads and derives SCL edges plus START/STOP conditions.
`timescale 1ns / 1ps
module i2c_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_hist_q, sda_hist_q;

  // Reset to the idle-bus level so no edge is seen when reset releases.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  assign sda_o       = sda_sync_q[1];
  assign scl_rise_o  = scl_sync_q[1] & ~scl_hist_q;
  assign scl_fall_o  = ~scl_sync_q[1] & scl_hist_q;
  assign start_det_o = scl_sync_q[1] & scl_hist_q & sda_hist_q & ~sda_sync_q[1];
  assign stop_det_o  = scl_sync_q[1] & scl_hist_q & ~sda_hist_q & sda_sync_q[1];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a 16 x 8-bit register file; register 15 reads back status_in.
`timescale 1ns / 1ps
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h42,
  parameter int unsigned NREG     = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              scl_oe,
  output logic              sda_oe,
  input  logic [7:0]        status_in,
  output logic [8*NREG-1:0] regs_flat,
  output logic              wr_strobe,
  output logic [3:0]        wr_addr,
  output logic              busy
);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk_i       (clk_clk),
    .rst_i       (reset_reset),
    .scl_i       (scl_in),
    .sda_i       (sda_in),
    .sda_o       (sda_lvl),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] regs_q [NREG];
  logic [7:0] regs_d [NREG];
  logic [7:0] rx_byte, rd_byte;

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    regs_d      = regs_q;
    rx_byte     = {shift_q[6:0], sda_lvl};
    rd_byte     = (ptr_q == 4'hF) ? status_in : regs_q[ptr_q];

    if (stop_det) begin
      state_d  = StIdle;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = StAddr;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d  = rx_byte;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = 4'd0;
              rw_d     = sda_lvl;
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_d = StAddrAck;
                busy_d  = 1'b1;
              end else begin
                state_d = StIgnore;
              end
            end
          end
        end
        // In ACK states bitcnt marks whether the ACK is already being driven.
        StAddrAck: begin
          if (scl_fall) begin
            if (bitcnt_q == 4'd0) begin
              sda_oe_d = 1'b1;
              bitcnt_d = 4'd1;
            end else begin
              bitcnt_d = 4'd0;
              if (rw_q == I2C_RD) begin
                state_d  = StRdata;
                shift_d  = rd_byte;
                sda_oe_d = ~rd_byte[7];
              end else begin
                state_d  = StPtr;
                sda_oe_d = 1'b0;
              end
            end
          end
        end
        StPtr: begin
          if (scl_rise) begin
            shift_d  = rx_byte;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = 4'd0;
              ptr_d    = rx_byte[3:0];
              state_d  = StPtrAck;
            end
          end
        end
        StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (bitcnt_q == 4'd0) begin
              sda_oe_d = 1'b1;
              bitcnt_d = 4'd1;
            end else begin
              sda_oe_d = 1'b0;
              bitcnt_d = 4'd0;
              state_d  = StWdata;
            end
          end
        end
        StWdata: begin
          if (scl_rise) begin
            shift_d  = rx_byte;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = 4'd0;
              if (ptr_q != 4'hF) begin
                regs_d[ptr_q] = rx_byte;
                wr_strobe_d   = 1'b1;
                wr_addr_d     = ptr_q;
              end
              ptr_d   = ptr_q + 4'd1;
              state_d = StWdataAck;
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              bitcnt_d = 4'd0;
              state_d  = StRdataAck;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        StRdataAck: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_ACK) begin
              ptr_d    = ptr_q + 4'd1;
              bitcnt_d = 4'd1;
            end else begin
              state_d = StIgnore;
            end
          end else if (scl_fall && bitcnt_q == 4'd1) begin
            bitcnt_d = 4'd0;
            shift_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
            state_d  = StRdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q     <= StIdle;
      bitcnt_q    <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 4'd0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'd0;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs_q[g];
  end

  assign scl_oe    = 1'b0;
  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller against a transaction-level register model.
`timescale 1ns / 1ps
module tb_i2c_target_regs;

  localparam int Q = 8;
  localparam logic [7:0] AddrW = 8'h84;
  localparam logic [7:0] AddrR = 8'h85;

  logic         clk_clk = 1'b0;
  logic         reset_reset = 1'b1;
  logic         scl_drv = 1'b1;
  logic         sda_drv = 1'b1;
  logic         scl_in, sda_in, scl_oe, sda_oe, wr_strobe, busy;
  logic [3:0]   wr_addr;
  logic [7:0]   status_in = 8'h00;
  logic [127:0] regs_flat;

  assign scl_in = scl_drv & ~scl_oe;
  assign sda_in = sda_drv & ~sda_oe;

  i2c_target_regs #(.DEV_ADDR(7'h42)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .scl_oe      (scl_oe),
    .sda_oe      (sda_oe),
    .status_in   (status_in),
    .regs_flat   (regs_flat),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .busy        (busy)
  );

  always #5 clk_clk = ~clk_clk;

  int errors = 0;
  int checks = 0;

  // Monitors: monotonically increasing counters; tests look at deltas.
  int         strobe_cnt = 0;
  int         oe_cnt = 0;
  int         busy_cnt = 0;
  logic [3:0] last_addr = 4'd0;
  logic [7:0] last_byte = 8'h00;

  always @(posedge clk_clk) begin
    if (wr_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      last_addr  <= wr_addr;
      last_byte  <= regs_flat[wr_addr*8 +: 8];
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // Reference model
  logic [7:0] m_regs [16];
  int         m_ptr = 0;
  int         m_strobes = 0;
  int         m_last_addr = 0;
  logic [7:0] wbuf [4];
  logic [7:0] rbuf [4];

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
  endfunction

  function automatic void m_write_byte(input logic [7:0] d);
    if (m_ptr != 15) begin
      m_regs[m_ptr] = d;
      m_strobes++;
      m_last_addr = m_ptr;
    end
    m_ptr = (m_ptr + 1) % 16;
  endfunction

  function automatic logic [7:0] m_read();
    return (m_ptr == 15) ? status_in : m_regs[m_ptr];
  endfunction

  function automatic logic [127:0] m_flat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  // Bus primitives
  task automatic wq();
    repeat (Q) @(negedge clk_clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wq();
    scl_drv = 1'b1; wq();
    sda_drv = 1'b0; wq();
    scl_drv = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wq();
    scl_drv = 1'b1; wq();
    sda_drv = 1'b1; wq();
    wq();
  endtask

  task automatic put_bit(input logic b);
    sda_drv = b; wq();
    scl_drv = 1'b1; wq(); wq();
    scl_drv = 1'b0; wq();
  endtask

  task automatic get_bit(output logic b);
    sda_drv = 1'b1; wq();
    scl_drv = 1'b1; wq();
    b = sda_in; wq();
    scl_drv = 1'b0; wq();
  endtask

  task automatic put_byte(input logic [7:0] d, output logic nack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(nack);
  endtask

  task automatic get_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic do_write(input logic [3:0] ptr, input int n, output int nacks);
    logic a;
    nacks = 0;
    i2c_start();
    put_byte(AddrW, a); if (a) nacks++;
    put_byte({4'h0, ptr}, a); if (a) nacks++;
    m_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      put_byte(wbuf[i], a); if (a) nacks++;
      m_write_byte(wbuf[i]);
    end
    i2c_stop();
  endtask

  task automatic do_read(input logic [3:0] ptr, input int n, output int nacks);
    logic a;
    nacks = 0;
    i2c_start();
    put_byte(AddrW, a); if (a) nacks++;
    put_byte({4'h0, ptr}, a); if (a) nacks++;
    i2c_start();
    put_byte(AddrR, a); if (a) nacks++;
    for (int i = 0; i < n; i++) get_byte(i == n - 1, rbuf[i]);
    i2c_stop();
  endtask

  // Tests
  task automatic test_reset();
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL reset_scl_oe got=%b exp=0", scl_oe); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe got=%b exp=0", wr_strobe); end
    checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (regs_flat !== 128'h0) begin errors++; $display("FAIL reset_regs got=%h exp=0", regs_flat); end
  endtask

  task automatic test_write();
    int s0, nacks;
    logic a;
    s0 = strobe_cnt;
    nacks = 0;
    i2c_start();
    put_byte(AddrW, a); if (a) nacks++;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_on got=%b exp=1", busy); end
    put_byte(8'h02, a); if (a) nacks++;
    m_ptr = 2;
    put_byte(8'h5A, a); if (a) nacks++;
    m_write_byte(8'h5A);
    i2c_stop();
    checks++; if (nacks !== 0) begin errors++; $display("FAIL write_acks got=%0d nacks exp=0", nacks); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_off got=%b exp=0", busy); end
    checks++; if (regs_flat[23:16] !== 8'h5A) begin errors++; $display("FAIL write_reg2 got=%h exp=5a", regs_flat[23:16]); end
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL write_strobes got=%0d exp=1", strobe_cnt - s0); end
    checks++; if (last_addr !== 4'd2 || last_byte !== 8'h5A) begin
      errors++; $display("FAIL write_strobe_data got=%0d/%h exp=2/5a", last_addr, last_byte);
    end
  endtask

  task automatic test_combined_read();
    int nacks;
    logic [7:0] e0, e1;
    m_ptr = 2; e0 = m_read();
    m_ptr = 3; e1 = m_read();
    do_read(4'h2, 2, nacks);
    checks++; if (nacks !== 0) begin errors++; $display("FAIL cread_acks got=%0d exp=0", nacks); end
    checks++; if (rbuf[0] !== e0) begin errors++; $display("FAIL cread_byte0 got=%h exp=%h", rbuf[0], e0); end
    checks++; if (rbuf[1] !== e1) begin errors++; $display("FAIL cread_byte1 got=%h exp=%h", rbuf[1], e1); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL cread_release got=%b exp=0", sda_oe); end
  endtask

  task automatic test_addr_mismatch();
    int s0, o0, b0, acks;
    logic a;
    s0 = strobe_cnt; o0 = oe_cnt; b0 = busy_cnt; acks = 0;
    i2c_start();
    put_byte(8'h90, a); if (!a) acks++;
    put_byte(8'h01, a); if (!a) acks++;
    put_byte(8'hFF, a); if (!a) acks++;
    i2c_stop();
    checks++; if (acks !== 0) begin errors++; $display("FAIL mismatch_acks got=%0d exp=0", acks); end
    checks++; if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL mismatch_sda_oe cycles=%0d exp=0", oe_cnt - o0); end
    checks++; if (busy_cnt - b0 !== 0) begin errors++; $display("FAIL mismatch_busy cycles=%0d exp=0", busy_cnt - b0); end
    checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL mismatch_strobes got=%0d exp=0", strobe_cnt - s0); end
    checks++; if (regs_flat !== m_flat()) begin errors++; $display("FAIL mismatch_regs got=%h exp=%h", regs_flat, m_flat()); end
  endtask

  task automatic test_wrap_readonly();
    int s0, nacks;
    s0 = strobe_cnt;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(4'hE, 3, nacks);
    checks++; if (nacks !== 0) begin errors++; $display("FAIL wrap_acks got=%0d exp=0", nacks); end
    checks++; if (strobe_cnt - s0 !== 2) begin errors++; $display("FAIL wrap_strobes got=%0d exp=2", strobe_cnt - s0); end
    checks++; if (regs_flat[119:112] !== 8'h11) begin errors++; $display("FAIL wrap_reg14 got=%h exp=11", regs_flat[119:112]); end
    checks++; if (regs_flat[127:120] !== 8'h00) begin errors++; $display("FAIL wrap_reg15 got=%h exp=00", regs_flat[127:120]); end
    checks++; if (regs_flat[7:0] !== 8'h33) begin errors++; $display("FAIL wrap_reg0 got=%h exp=33", regs_flat[7:0]); end
    checks++; if (last_addr !== 4'd0) begin errors++; $display("FAIL wrap_wr_addr got=%0d exp=0", last_addr); end
    status_in = 8'hC3;
    do_read(4'hF, 1, nacks);
    m_ptr = 15;
    checks++; if (rbuf[0] !== 8'hC3) begin errors++; $display("FAIL status_read got=%h exp=c3", rbuf[0]); end
  endtask

  task automatic test_stop_mid_byte();
    int s0;
    logic a;
    logic [7:0] got, exp;
    s0 = strobe_cnt;
    i2c_start();
    put_byte(AddrW, a);
    put_byte(8'h07, a);
    m_ptr = 7;
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    i2c_stop();
    checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL midstop_strobes got=%0d exp=0", strobe_cnt - s0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midstop_busy got=%b exp=0", busy); end
    checks++; if (regs_flat !== m_flat()) begin errors++; $display("FAIL midstop_regs got=%h exp=%h", regs_flat, m_flat()); end
    // Pointer persists: a bare read resumes at register 7.
    exp = m_read();
    i2c_start();
    put_byte(AddrR, a);
    get_byte(1'b1, got);
    i2c_stop();
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL midstop_readack got=%b exp=0", a); end
    checks++; if (got !== exp) begin errors++; $display("FAIL midstop_persist got=%h exp=%h", got, exp); end
  endtask

  task automatic test_random();
    int nacks, n, s0, o0;
    logic [3:0] p;
    logic [7:0] bad, exp;
    logic a;
    for (int it = 0; it < 6; it++) begin
      p = 4'($urandom_range(0, 15));
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      s0 = strobe_cnt;
      m_strobes = 0;
      do_write(p, n, nacks);
      checks++; if (nacks !== 0) begin errors++; $display("FAIL rnd%0d_wacks got=%0d exp=0", it, nacks); end
      checks++; if (strobe_cnt - s0 !== m_strobes) begin
        errors++; $display("FAIL rnd%0d_strobes got=%0d exp=%0d", it, strobe_cnt - s0, m_strobes);
      end
      checks++; if (regs_flat !== m_flat()) begin errors++; $display("FAIL rnd%0d_regs got=%h exp=%h", it, regs_flat, m_flat()); end
      if (m_strobes > 0) begin
        checks++; if (last_addr !== 4'(m_last_addr)) begin
          errors++; $display("FAIL rnd%0d_wr_addr got=%0d exp=%0d", it, last_addr, m_last_addr);
        end
      end
      p = 4'($urandom_range(0, 15));
      n = $urandom_range(1, 4);
      status_in = 8'($urandom);
      do_read(p, n, nacks);
      checks++; if (nacks !== 0) begin errors++; $display("FAIL rnd%0d_racks got=%0d exp=0", it, nacks); end
      m_ptr = p;
      for (int i = 0; i < n; i++) begin
        exp = m_read();
        checks++; if (rbuf[i] !== exp) begin errors++; $display("FAIL rnd%0d_rd%0d got=%h exp=%h", it, i, rbuf[i], exp); end
        if (i != n - 1) m_ptr = (m_ptr + 1) % 16;
      end
      if (it % 2 == 0) begin
        bad = 8'($urandom);
        if (bad[7:1] == 7'h42) bad[7] = ~bad[7];
        o0 = oe_cnt;
        i2c_start();
        put_byte(bad, a);
        put_byte(8'($urandom), a);
        i2c_stop();
        checks++; if (oe_cnt - o0 !== 0) begin
          errors++; $display("FAIL rnd%0d_badaddr %h sda_oe cycles=%0d exp=0", it, bad, oe_cnt - o0);
        end
      end
    end
    checks++; if (regs_flat !== m_flat()) begin errors++; $display("FAIL rnd_final_regs got=%h exp=%h", regs_flat, m_flat()); end
  endtask

  task automatic test_reset_mid_read();
    int nacks;
    logic a;
    wbuf[0] = 8'h3C;
    do_write(4'h5, 1, nacks);
    i2c_start();
    put_byte(AddrW, a);
    put_byte(8'h05, a);
    i2c_start();
    put_byte(AddrR, a);
    sda_drv = 1'b1; wq();
    scl_drv = 1'b1; wq();
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstread_driving got=%b exp=1", sda_oe); end
    #2 reset_reset = 1'b1;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstread_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (regs_flat !== 128'h0) begin errors++; $display("FAIL rstread_regs got=%h exp=0", regs_flat); end
    checks++; if (busy !== 1'b0 || wr_addr !== 4'd0) begin
      errors++; $display("FAIL rstread_outs busy=%b wr_addr=%0d exp=0/0", busy, wr_addr);
    end
    m_reset();
    repeat (4) @(negedge clk_clk);
    reset_reset = 1'b0;
    wq();
    wbuf[0] = 8'h77;
    do_write(4'h1, 1, nacks);
    checks++; if (regs_flat !== m_flat()) begin errors++; $display("FAIL rstread_recover got=%h exp=%h", regs_flat, m_flat()); end
  endtask

  initial begin
    m_reset();
    repeat (4) @(negedge clk_clk);
    #1 test_reset();
    reset_reset = 1'b0;
    wq();
    test_write();
    test_combined_read();
    test_addr_mismatch();
    test_wrap_readonly();
    test_stop_mid_byte();
    test_random();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
